// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle events into a programmable-length level
//
// Turns event pulses into an active-high level of len cycles. Optional
// retrigger extends the level, and an optional holdoff window follows each
// stretch. Ignored events are counted, and a strobe marks the end of each stretch.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_pulse   event input, one event per sampled high cycle
//   len        stretch length in cycles (0 behaves as 1)
//   holdoff    dead time after a stretch in cycles (0 = none)
//   retrig     1: event during stretch restarts length, 0: event dropped
//   clr_drop   synchronous clear of drop_cnt
//   out_level  stretched level (registered)
//   busy       high while not idle (registered)
//   done       one-cycle strobe after each stretch ends
//   drop_cnt   saturating count of ignored events

module pulse_stretcher #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_pulse,
  input  logic [CNT_W-1:0]  len,
  input  logic [CNT_W-1:0]  holdoff,
  input  logic              retrig,
  input  logic              clr_drop,
  output logic              out_level,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_HOLDOFF = 2'd2;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_level;
  logic              r_busy;
  logic              r_done;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_reload;
  logic             w_drop;

  // len of 0 loads the same count as len of 1, so the level is never shorter than one cycle
  assign w_len_m1 = (len == '0) ? '0 : (len - CNT_ONE);
  assign w_reload = in_pulse && (r_state == S_STRETCH) && retrig;
  // Only IDLE accepts; events in HOLDOFF (including its last cycle) are lost
  assign w_drop   = in_pulse && (((r_state == S_STRETCH) && !retrig) ||
                                 (r_state == S_HOLDOFF));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_pulse) begin
          w_state_nxt = S_STRETCH;
          w_cnt_nxt   = w_len_m1;
        end
      end
      S_STRETCH: begin
        // Retrigger wins over expiry in the same cycle
        if (w_reload) begin
          w_cnt_nxt = w_len_m1;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_done_nxt = 1'b1;
          if (holdoff == '0) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_HOLDOFF;
            w_cnt_nxt   = holdoff - CNT_ONE;
          end
        end
      end
      S_HOLDOFF: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_level <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // Outputs follow the next state so they change on the same edge as the state
      r_out_level <= (w_state_nxt == S_STRETCH);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (clr_drop) begin
      r_drop_cnt <= '0;
    end else if (w_drop && !(&r_drop_cnt)) begin
      r_drop_cnt <= r_drop_cnt + DROP_ONE;
    end
  end

  assign out_level = r_out_level;
  assign busy      = r_busy;
  assign done      = r_done;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher

module tb_pulse_stretcher;

  logic        clk;
  logic        rst_n;
  logic        in_pulse;
  logic [15:0] len;
  logic [15:0] holdoff;
  logic        retrig;
  logic        clr_drop;
  logic        out_level;
  logic        busy;
  logic        done;
  logic [7:0]  drop_cnt;

  typedef struct packed {
    logic       o;
    logic       b;
    logic       d;
    logic [7:0] drop;
  } exp_t;

  exp_t sb[$];
  int   n_total;
  int   n_bad;
  int   m_drop;

  pulse_stretcher #(.CNT_W(16), .DROP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pulse  (in_pulse),
    .len       (len),
    .holdoff   (holdoff),
    .retrig    (retrig),
    .clr_drop  (clr_drop),
    .out_level (out_level),
    .busy      (busy),
    .done      (done),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, queues what the DUT must show after the
  // next edge, then pops and compares it.
  task automatic step(input logic p, input logic clr, input logic eo,
                      input logic eb, input logic ed, input logic dinc);
    exp_t e;
    in_pulse = p;
    clr_drop = clr;
    if (clr) m_drop = 0;
    else if (dinc && m_drop != 255) m_drop++;
    sb.push_back({eo, eb, ed, 8'(m_drop)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out_level", {31'd0, out_level}, {31'd0, e.o});
      chk("busy", {31'd0, busy}, {31'd0, e.b});
      chk("done", {31'd0, done}, {31'd0, e.d});
      chk("drop_cnt", {24'd0, drop_cnt}, {24'd0, e.drop});
    end
    in_pulse = 1'b0;
    clr_drop = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_out"}, {31'd0, out_level}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_drop"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    n_total = 0; n_bad = 0; m_drop = 0;
    rst_n = 1'b0; in_pulse = 1'b0; clr_drop = 1'b0;
    len = 16'd5; holdoff = 16'd0; retrig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    // single pulse, len=5
    step(1, 0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // len=0 acts as 1
    len = 16'd0;
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // len changed mid-stretch does not affect running count
    len = 16'd3;
    step(1, 0, 1, 1, 0, 0);
    len = 16'd10;
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // retrigger, len=4, pulses at t=0,2 -> 6 high cycles
    len = 16'd4; retrig = 1'b1;
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // same without retrigger -> 4 high cycles, one drop
    retrig = 1'b0;
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 1);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("drop_after_noretrig", {24'd0, drop_cnt}, 32'd1);
    step(0, 1, 0, 0, 0, 0);

    // continuous input with retrigger: high until len cycles after it falls
    len = 16'd3; retrig = 1'b1;
    repeat (5) step(1, 0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // holdoff: len=3, holdoff=4
    len = 16'd3; holdoff = 16'd4; retrig = 1'b0;
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("drop_after_holdoff", {24'd0, drop_cnt}, 32'd2);
    step(0, 1, 0, 0, 0, 0);
    holdoff = 16'd0;

    // saturation: 300 drops, then clear coincident with a drop
    len = 16'd400; retrig = 1'b0;
    step(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 0, 1, 1, 0, 1);
    chk("drop_saturated", {24'd0, drop_cnt}, 32'd255);
    step(1, 1, 1, 1, 0, 1);
    rst_n = 1'b0;
    #2;
    m_drop = 0;
    check_idle("reset2");
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset mid-stretch, len=10
    len = 16'd10;
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (9) step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses into a sustained active-high level of programmable length.
- Used to drive LEDs, buzzers and slow-domain enables from pulse sources such as edge detectors, counters and key decoders.
- Supports optional retrigger (extend on new event) and a programmable holdoff window after each stretch.
- Reports dropped events and emits an end-of-stretch strobe.

Parameters:
- CNT_W, 16, width of the len/holdoff inputs and the internal down-counter.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_pulse  input  1  event input; every rising clk edge with in_pulse=1 is one event.
- len  input  CNT_W  stretch length in clk cycles; 0 is treated as 1.
- holdoff  input  CNT_W  dead time after stretch in clk cycles; 0 means no holdoff.
- retrig  input  1  1 = event during STRETCH restarts the length; 0 = event dropped.
- clr_drop  input  1  synchronous clear of drop_cnt.
- out_level  output  1  stretched level, registered.
- busy  output  1  high whenever state is not IDLE, registered.
- done  output  1  one-cycle strobe at the end of each stretch.
- drop_cnt  output  DROP_W  saturating count of ignored events.

Behaviour:
- Reset (asynchronous, active-low), applied at any time including mid-stretch:
  - state=IDLE; cnt=0; out_level=0; busy=0; done=0; drop_cnt=0.
  - Outputs go low immediately on assertion.
- States and transitions:
  - IDLE, event accepted: load cnt=max(len,1)-1; state=STRETCH; out_level=1 and busy=1 from the next edge.
  - STRETCH, event with retrig=1: reload cnt=max(len,1)-1 using current len; stay in STRETCH. Retrigger has priority over expiry in the same cycle.
  - STRETCH, cnt!=0 and no retrigger: cnt decrements.
  - STRETCH, cnt==0 and no retrigger, expiry:
    - holdoff==0: go to IDLE.
    - holdoff!=0: go to HOLDOFF with cnt=holdoff-1.
    - out_level=0 and done=1 on the following cycle, for exactly one cycle.
  - HOLDOFF: out_level=0, busy=1. cnt decrements; at cnt==0 go to IDLE, with busy=0 from the next edge.
- Timing:
  - Event sampled at edge k gives out_level high for exactly len cycles (edges k..k+len-1), or len cycles after the last retrigger.
  - Latency from sampled event to out_level is 1 cycle.
- Dropped events, each incrementing drop_cnt:
  - any event in STRETCH with retrig=0;
  - any event in HOLDOFF, including its final cycle.
  - An event arriving in the same cycle HOLDOFF→IDLE occurs is dropped. Only events sampled while state==IDLE are accepted.
- drop_cnt:
  - Saturates at 2^DROP_W-1.
  - clr_drop wins over a simultaneous drop, giving 0.
- Inputs are used only on the cycle they are loaded:
  - len is sampled only at accept or reload; later changes do not affect the running count.
  - holdoff is sampled only at expiry.
- No arithmetic wrap: cnt never decrements below 0, and len/holdoff at all-ones are valid (2^CNT_W-1 cycles).
- A continuously high in_pulse counts one event per cycle:
  - retrig=1: out_level stays high until len cycles after in_pulse falls.
  - retrig=0: one stretch, with the remaining events dropped.

Test Plan:
- Reset, then single pulse with len=5, holdoff=0 -> out_level high for exactly 5 cycles starting one cycle after the pulse; done=1 on the 6th cycle; busy falls with out_level; drop_cnt=0.
- len=0, single pulse -> out_level high for exactly 1 cycle, done next cycle.
- len=4, retrig=1, pulses at t=0 and t=2 -> out_level high for 6 cycles continuous; one done; drop_cnt=0. Same stimulus with retrig=0 -> high 4 cycles; drop_cnt=1.
- len=3, holdoff=4, pulses at t=0, then during holdoff, then on the holdoff→IDLE cycle, then one cycle later -> first and last accepted; the two middle pulses dropped (drop_cnt=2); second stretch is 3 cycles.
- DROP_W=8, 300 drop events with retrig=0 -> drop_cnt saturates at 255. Then clr_drop coincident with a drop -> drop_cnt=0.
- Assert rst_n low on cycle 2 of len=10 stretch -> out_level, busy, done=0 immediately. After release with no event -> remains IDLE. Next pulse -> full 10-cycle stretch.
